// File: rtl/johnson_decoder.sv
// johnson_decoder
//   Receive-side monitor for a WIDTH-bit Johnson counter bus. It samples the
//   code, checks that the code is legal, and decodes it to a state index in
//   [0, 2*WIDTH-1]. It then classifies each change as an adjacent step (with
//   direction), a skip, or an illegal code.
//
//   Pipeline (default build): capture -> decode/classify -> registered outputs.
//   There are two clock edges from the capture edge to the outputs.
//
//   Optional feature, macro JDEC_GLITCH_FILTER_EN: one extra stage is added.
//   A captured code goes on to decode only if it equals the code captured just
//   before it. Latency becomes three edges.
//
//   Input qualifier: sample_i is a plain valid strobe and has no ready. The
//   block accepts one code on every cycle that sample_i is high. A cycle
//   without sample_i moves a bubble through the pipeline. A bubble produces
//   no pulse and leaves every output unchanged.
module johnson_decoder #(
  parameter int WIDTH = 16,
  localparam int IW = $clog2(2 * WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sample_i,
  input  logic [WIDTH-1:0] code_i,
  input  logic             clr_i,
  output logic [IW-1:0]    idx_o,
  output logic             valid_o,
  output logic             step_o,
  output logic             dir_o,
  output logic             skip_o,
  output logic             err_o,
  output logic [15:0]      steps_o,
  output logic [7:0]       errs_o
);

  // Number of states in the Johnson sequence.
  localparam int NST = 2 * WIDTH;
  // This width holds a count in the range 0..WIDTH.
  localparam int CW  = $clog2(WIDTH + 1);

  // ---------------------------------------------------------------------------
  // Stage 1: capture
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] cap_code;
  logic             cap_vld;

  // Register the incoming code when sample_i is high. Reset drops any
  // in-flight sample.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cap_vld  <= 1'b0;
      cap_code <= '0;
    end else begin
      cap_vld <= sample_i;
      if (sample_i) begin
        cap_code <= code_i;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional glitch filter: a code passes only when two consecutive captured
  // samples agree.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] dec_code;
  logic             dec_vld;

`ifdef JDEC_GLITCH_FILTER_EN
  logic [WIDTH-1:0] last_code;
  logic             have_last;
  logic [WIDTH-1:0] flt_code;
  logic             flt_vld;

  // Compare each captured code with the one captured before it. The first
  // sample after reset has nothing to compare with, so it never passes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_code <= '0;
      have_last <= 1'b0;
      flt_code  <= '0;
      flt_vld   <= 1'b0;
    end else begin
      flt_vld <= cap_vld && have_last && (cap_code == last_code);
      if (cap_vld) begin
        last_code <= cap_code;
        have_last <= 1'b1;
        flt_code  <= cap_code;
      end
    end
  end

  // Filtered samples feed the decoder.
  always_comb begin
    dec_code = flt_code;
    dec_vld  = flt_vld;
  end
`else
  // Every captured sample feeds the decoder directly.
  always_comb begin
    dec_code = cap_code;
    dec_vld  = cap_vld;
  end
`endif

  // ---------------------------------------------------------------------------
  // Decode: legality check and index
  // ---------------------------------------------------------------------------
  logic [CW-1:0]   ones_cnt;
  logic [CW-1:0]   zero_cnt;
  logic [CW-1:0]   trans_cnt;
  logic            code_legal;
  logic [IW-1:0]   dec_idx;

  // A legal Johnson code has at most one boundary between runs of ones and
  // zeros. The index is the number of ones when the MSB is 0. When the MSB
  // is 1, the index is WIDTH plus the number of zeros.
  always_comb begin
    ones_cnt  = '0;
    trans_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones_cnt = ones_cnt + CW'(dec_code[i]);
    end
    for (int i = 0; i < WIDTH - 1; i++) begin
      trans_cnt = trans_cnt + CW'(dec_code[i] ^ dec_code[i+1]);
    end
    zero_cnt   = CW'(WIDTH) - ones_cnt;
    code_legal = (trans_cnt <= CW'(1));
    if (!dec_code[WIDTH-1]) begin
      dec_idx = IW'(ones_cnt);
    end else begin
      dec_idx = IW'(WIDTH) + IW'(zero_cnt);
    end
  end

  // ---------------------------------------------------------------------------
  // Classify against the previous legal index (idx_o doubles as prev_idx)
  // ---------------------------------------------------------------------------
  logic          have_prev;
  logic [IW:0]   diff;
  logic          is_fwd;
  logic          is_bwd;
  logic          ev_legal;
  logic          ev_first;
  logic          ev_err;
  logic          ev_step;
  logic          ev_skip;

  // Compute the forward distance modulo 2*WIDTH, then turn it into events.
  // The extra bit in diff keeps the sum from overflowing when 2*WIDTH is
  // not a power of two.
  always_comb begin
    if (dec_idx >= idx_o) begin
      diff = {1'b0, dec_idx} - {1'b0, idx_o};
    end else begin
      diff = {1'b0, dec_idx} + (IW + 1)'(NST) - {1'b0, idx_o};
    end
    is_fwd   = (diff == (IW + 1)'(1));
    is_bwd   = (diff == (IW + 1)'(NST - 1));
    ev_legal = dec_vld && code_legal;
    ev_err   = dec_vld && !code_legal;
    ev_first = ev_legal && !have_prev;
    ev_step  = ev_legal && have_prev && (is_fwd || is_bwd);
    ev_skip  = ev_legal && have_prev && !is_fwd && !is_bwd && (diff != '0);
  end

  // ---------------------------------------------------------------------------
  // Counters: a clear takes effect first, then any event in the same cycle
  // adds to the cleared value.
  // ---------------------------------------------------------------------------
  logic [15:0] steps_base;
  logic [15:0] steps_nxt;
  logic [7:0]  errs_base;
  logic [7:0]  errs_nxt;
  logic        skip_nxt;

  // Build the next counter and sticky-flag values from the clear and the events.
  always_comb begin
    steps_base = clr_i ? 16'd0 : steps_o;
    errs_base  = clr_i ? 8'd0 : errs_o;
    steps_nxt  = steps_base + {15'd0, ev_step};
    if (ev_err && (errs_base != 8'hFF)) begin
      errs_nxt = errs_base + 8'd1;
    end else begin
      errs_nxt = errs_base;
    end
    skip_nxt = (clr_i ? 1'b0 : skip_o) | ev_skip;
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  // Register the pulses, counters and decoded index. An illegal code leaves
  // the index, valid and have_prev untouched.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_o     <= '0;
      valid_o   <= 1'b0;
      have_prev <= 1'b0;
      step_o    <= 1'b0;
      dir_o     <= 1'b0;
      skip_o    <= 1'b0;
      err_o     <= 1'b0;
      steps_o   <= '0;
      errs_o    <= '0;
    end else begin
      step_o  <= ev_step;
      err_o   <= ev_err;
      steps_o <= steps_nxt;
      errs_o  <= errs_nxt;
      skip_o  <= skip_nxt;
      if (ev_legal) begin
        idx_o <= dec_idx;
      end
      if (ev_first) begin
        valid_o   <= 1'b1;
        have_prev <= 1'b1;
      end
      if (ev_step) begin
        dir_o <= is_bwd;
      end
    end
  end

endmodule
